wb_host_arbiter: RTL and testbench

//   Shares the single Wishbone host port of the x8 device router between NM bus

---
 rtl/wb_host_arbiter_pkg.sv | 20 ++
 rtl/wb_rr_pick.sv | 34 +++
 rtl/wb_host_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_host_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_host_arbiter_pkg.sv
// Shared definitions for the Wishbone host-port arbiter: FSM state encoding,
// default watchdog limit and a helper for sizing the watchdog counter.
// Latency: n/a (package). Backpressure: n/a.
package wb_host_arbiter_pkg;

   // Arbiter owns nobody (IDLE) or exactly one master for a whole cyc (BUSY).
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Stb cycles without ack/err before the watchdog answers with err.
   localparam int WB_TIMEOUT_DEFAULT = 255;

   // Width needed to count 0..t-1; a disabled watchdog still gets a legal width.
   function automatic int wd_cnt_width(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after the last winner, wrapping.
// Latency: zero (pure combinational). Backpressure: none, gnt is 0 when req is 0.
// Ports: req[N] requests, last[N] one-hot previous winner, gnt[N] one-hot winner.
module wb_rr_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] last,
   output logic [N-1:0] gnt
);

   int   last_idx;
   logic found;

   always_comb begin
      gnt      = '0;
      last_idx = 0;
      found    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (last[i]) last_idx = i;
      end
      // Scan from the slot just after the previous winner; the previous winner
      // itself is examined last so it cannot starve the others.
      for (int off = 1; off <= N; off++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && (i == ((last_idx + off) % N)) && req[i]) begin
               gnt[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/wb_host_arbiter.sv
// Shares one Wishbone host port among NM masters; round-robin grant held for a whole cyc.
// Latency: 1 cycle master cyc -> host cyc; ack/err/rdata return with zero latency.
// Backpressure: losers wait with cyc/stb up and see no ack/err; watchdog errs a stalled owner.
// Ports: i_m* packed per-master request buses (slice i = master i), o_mack/o_merr per master,
//   o_mdata broadcast read data, wb_host_* router side, o_grant one-hot owner, o_timeout pulse.
module wb_host_arbiter
   import wb_host_arbiter_pkg::*;
#(
   parameter int NM      = 3,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SW      = DW / 8,
   parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NM-1:0]    i_mcyc,
   input  logic [NM-1:0]    i_mstb,
   input  logic [NM-1:0]    i_mwe,
   input  logic [NM*AW-1:0] i_maddr,
   input  logic [NM*DW-1:0] i_mdata,
   input  logic [NM*SW-1:0] i_msel,
   output logic [NM-1:0]    o_mack,
   output logic [NM-1:0]    o_merr,
   output logic [DW-1:0]    o_mdata,
   output logic             wb_host_cyc,
   output logic             wb_host_stb,
   output logic             wb_host_we,
   output logic [AW-1:0]    wb_host_addr,
   output logic [DW-1:0]    wb_host_wdata,
   output logic [SW-1:0]    wb_host_sel,
   input  logic             wb_host_ack,
   input  logic             wb_host_err,
   input  logic [DW-1:0]    wb_host_rdata,
   output logic [NM-1:0]    o_grant,
   output logic             o_timeout
);

   state_t          state_q, state_d;
   logic [NM-1:0]   grant_q, grant_d;
   logic [NM-1:0]   ptr_q, ptr_d;
   logic [NM-1:0]   pick;
   logic            wd_fire;

   wb_rr_pick #(.N(NM)) u_pick (
      .req  (i_mcyc),
      .last (ptr_q),
      .gnt  (pick)
   );

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= {1'b1, {(NM-1){1'b0}}};   // last = NM-1, so master 0 goes first
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (|i_mcyc) begin
               grant_d = pick;
               ptr_d   = pick;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Owner keeps the port until its own cyc drops; other requests are ignored.
            if (!wb_host_cyc) begin
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------- host-side mux ----------------
   // Gating with grant_q makes cyc/stb drop the same cycle the owner releases
   // and keeps everything at 0 while idle or in reset.
   assign wb_host_cyc = |(i_mcyc & grant_q);
   assign wb_host_stb = |(i_mcyc & i_mstb & grant_q);

   always_comb begin
      wb_host_we    = 1'b0;
      wb_host_addr  = '0;
      wb_host_wdata = '0;
      wb_host_sel   = '0;
      for (int i = 0; i < NM; i++) begin
         if (grant_q[i]) begin
            wb_host_we    = i_mwe[i];
            wb_host_addr  = i_maddr[i*AW +: AW];
            wb_host_wdata = i_mdata[i*DW +: DW];
            wb_host_sel   = i_msel[i*SW +: SW];
         end
      end
   end

   // ---------------- master-side return ----------------
   assign o_mack  = grant_q & {NM{wb_host_ack}};
   assign o_merr  = grant_q & {NM{wb_host_err | wd_fire}};
   assign o_mdata = wb_host_rdata;
   assign o_grant = grant_q;

   // ---------------- bus-lockup watchdog ----------------
   if (TIMEOUT > 0) begin : g_wd
      localparam int            CW  = wd_cnt_width(TIMEOUT);
      localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q;
      logic          tmo_q;

      // A real ack in the expiry cycle wins: no err is synthesised.
      assign wd_fire = wb_host_stb && !wb_host_ack && !wb_host_err && (cnt_q == LIM);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
         end else begin
            tmo_q <= wd_fire;
            if (!wb_host_stb || wb_host_ack || wb_host_err || wd_fire) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end

      assign o_timeout = tmo_q;
   end else begin : g_no_wd
      assign wd_fire   = 1'b0;
      assign o_timeout = 1'b0;
   end

endmodule

// File: tb/tb_wb_host_arbiter.sv
// Self-checking bench for wb_host_arbiter (NM=3, TIMEOUT=4).
// Expected responses are queued when the device answer is driven and popped by a monitor.
// Grant/host-side checks are made inline at the falling edge.
module tb_wb_host_arbiter;

   localparam int NM  = 3;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = 4;
   localparam int TMO = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NM-1:0]    mcyc, mstb, mwe;
   logic [NM*AW-1:0] maddr;
   logic [NM*DW-1:0] mdata;
   logic [NM*SW-1:0] msel;
   logic [NM-1:0]    o_mack, o_merr, o_grant;
   logic [DW-1:0]    o_mdata;
   logic             host_cyc, host_stb, host_we, o_timeout;
   logic [AW-1:0]    host_addr;
   logic [DW-1:0]    host_wdata, host_rdata;
   logic [SW-1:0]    host_sel;
   logic             host_ack, host_err;

   always #5 clk = ~clk;

   wb_host_arbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_mcyc        (mcyc),
      .i_mstb        (mstb),
      .i_mwe         (mwe),
      .i_maddr       (maddr),
      .i_mdata       (mdata),
      .i_msel        (msel),
      .o_mack        (o_mack),
      .o_merr        (o_merr),
      .o_mdata       (o_mdata),
      .wb_host_cyc   (host_cyc),
      .wb_host_stb   (host_stb),
      .wb_host_we    (host_we),
      .wb_host_addr  (host_addr),
      .wb_host_wdata (host_wdata),
      .wb_host_sel   (host_sel),
      .wb_host_ack   (host_ack),
      .wb_host_err   (host_err),
      .wb_host_rdata (host_rdata),
      .o_grant       (o_grant),
      .o_timeout     (o_timeout)
   );

   typedef struct packed {
      logic [NM-1:0] ack;
      logic [NM-1:0] err;
      logic [DW-1:0] dat;
   } resp_t;

   resp_t sb_q[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_m(input int m, input logic cyc, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
      mcyc[m]             = cyc;
      mstb[m]             = cyc;
      mwe[m]              = we;
      maddr[m*AW +: AW]   = a;
      mdata[m*DW +: DW]   = d;
      msel[m*SW +: SW]    = s;
   endtask

   task automatic drop_m(input int m);
      mcyc[m] = 1'b0;
      mstb[m] = 1'b0;
   endtask

   task automatic expect_resp(input logic [NM-1:0] a, input logic [NM-1:0] e,
                              input logic [DW-1:0] d);
      resp_t r;
      r.ack = a;
      r.err = e;
      r.dat = d;
      sb_q.push_back(r);
   endtask

   task automatic do_reset(input string tag);
      rst        = 1'b1;
      mcyc       = '0;
      mstb       = '0;
      mwe        = '0;
      maddr      = '0;
      mdata      = '0;
      msel       = '0;
      host_ack   = 1'b0;
      host_err   = 1'b0;
      host_rdata = '0;
      #2;
      chk({tag, "_grant"},   o_grant,   '0);
      chk({tag, "_cyc"},     host_cyc,  '0);
      chk({tag, "_stb"},     host_stb,  '0);
      chk({tag, "_mack"},    o_mack,    '0);
      chk({tag, "_merr"},    o_merr,    '0);
      chk({tag, "_timeout"}, o_timeout, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Response monitor: any ack/err seen by a master must match the next queued answer.
   always @(negedge clk) begin
      if (!rst && ((|o_mack) || (|o_merr))) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", {o_mack, o_merr}, '0);
         end else begin
            resp_t e;
            e = sb_q.pop_front();
            chk("sb_ack",  o_mack,  e.ack);
            chk("sb_err",  o_merr,  e.err);
            chk("sb_data", o_mdata, e.dat);
         end
      end
   end

   initial begin
      int order[4];
      order = '{0, 1, 2, 0};

      do_reset("rst0");

      // ---- 1: single write from m1, device acks on the 3rd granted cycle ----
      tick();
      drive_m(1, 1'b1, 1'b1, 32'h3000_0010, 32'hDEADBEEF, 4'hF);
      sample();
      chk("t1_c0_cyc",   host_cyc, 1'b0);
      chk("t1_c0_grant", o_grant,  3'b000);
      tick();
      sample();
      chk("t1_grant", o_grant,    3'b010);
      chk("t1_cyc",   host_cyc,   1'b1);
      chk("t1_stb",   host_stb,   1'b1);
      chk("t1_we",    host_we,    1'b1);
      chk("t1_addr",  host_addr,  32'h3000_0010);
      chk("t1_wdata", host_wdata, 32'hDEADBEEF);
      chk("t1_sel",   host_sel,   4'hF);
      tick();
      sample();
      chk("t1_wait_mack", o_mack, 3'b000);
      tick();
      host_ack   = 1'b1;
      host_rdata = 32'h0000_0001;
      expect_resp(3'b010, 3'b000, 32'h0000_0001);
      sample();
      chk("t1_no_timeout", o_timeout, 1'b0);
      tick();
      host_ack = 1'b0;
      drop_m(1);
      sample();
      chk("t1_rel_cyc",   host_cyc, 1'b0);
      chk("t1_rel_grant", o_grant,  3'b010);
      tick();
      sample();
      chk("t1_idle_grant", o_grant, 3'b000);

      // ---- 2: three masters contend, each releases after one ack ----
      do_reset("rst1");
      tick();
      for (int m = 0; m < NM; m++) begin
         drive_m(m, 1'b1, 1'b0, 32'h1000_0000 + 32'(m), 32'h0, 4'h1);
      end
      sample();
      chk("t2_arb_latency", o_grant, 3'b000);
      for (int s = 0; s < 4; s++) begin
         logic [NM-1:0] oh;
         oh = 3'b001 << order[s];
         tick();
         sample();
         chk("t2_grant", o_grant,   oh);
         chk("t2_addr",  host_addr, 32'h1000_0000 + 32'(order[s]));
         tick();
         host_ack   = 1'b1;
         host_rdata = 32'hA000_0000 + 32'(s);
         expect_resp(oh, 3'b000, 32'hA000_0000 + 32'(s));
         sample();
         tick();
         host_ack = 1'b0;
         drop_m(order[s]);
         sample();
         chk("t2_rel_cyc", host_cyc, 1'b0);
         tick();
         if (s < 3) begin
            mcyc[order[s]] = 1'b1;
            mstb[order[s]] = 1'b1;
         end else begin
            mcyc = '0;
            mstb = '0;
         end
         sample();
         chk("t2_idle_gap", o_grant, 3'b000);
      end

      // ---- 3: m2 owns the bus, m0 requests mid-transfer ----
      tick();
      drive_m(2, 1'b1, 1'b0, 32'h2000_0020, 32'h0, 4'h3);
      sample();
      tick();
      sample();
      chk("t3_grant_m2", o_grant, 3'b100);
      tick();
      drive_m(0, 1'b1, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'hF);
      sample();
      chk("t3_hold",      o_grant,   3'b100);
      chk("t3_hold_addr", host_addr, 32'h2000_0020);
      chk("t3_hold_sel",  host_sel,  4'h3);
      tick();
      host_ack   = 1'b1;
      host_rdata = 32'hCAFE_0002;
      expect_resp(3'b100, 3'b000, 32'hCAFE_0002);
      sample();
      tick();
      host_ack = 1'b0;
      drop_m(2);
      sample();
      chk("t3_rel_grant", o_grant,  3'b100);
      chk("t3_rel_cyc",   host_cyc, 1'b0);
      tick();
      sample();
      chk("t3_idle", o_grant, 3'b000);
      tick();
      sample();
      chk("t3_grant_m0", o_grant,    3'b001);
      chk("t3_m0_we",    host_we,    1'b1);
      chk("t3_m0_wdata", host_wdata, 32'h5555_AAAA);
      tick();
      host_ack   = 1'b1;
      host_rdata = 32'hCAFE_0000;
      expect_resp(3'b001, 3'b000, 32'hCAFE_0000);
      sample();
      tick();
      host_ack = 1'b0;
      drop_m(0);
      sample();
      tick();
      sample();
      chk("t3_end_idle", o_grant, 3'b000);

      // ---- 4a: device never answers, watchdog errs on the 4th stb cycle ----
      host_rdata = 32'h0BAD_F00D;
      tick();
      drive_m(0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF);
      sample();
      for (int c = 1; c <= 3; c++) begin
         tick();
         sample();
         chk("t4_grant",   o_grant,   3'b001);
         chk("t4_no_err",  o_merr,    3'b000);
         chk("t4_no_tmo",  o_timeout, 1'b0);
      end
      tick();
      expect_resp(3'b000, 3'b001, 32'h0BAD_F00D);
      sample();
      chk("t4_fire_tmo_low", o_timeout, 1'b0);
      tick();
      drop_m(0);
      sample();
      chk("t4_tmo_pulse",   o_timeout, 1'b1);
      chk("t4_err_cleared", o_merr,    3'b000);
      tick();
      sample();
      chk("t4_tmo_end", o_timeout, 1'b0);
      chk("t4_idle",    o_grant,   3'b000);

      // ---- 4b: ack arrives exactly in the expiry cycle: ack wins ----
      tick();
      drive_m(0, 1'b1, 1'b0, 32'h4000_0004, 32'h0, 4'hF);
      sample();
      for (int c = 1; c <= 3; c++) begin
         tick();
         sample();
         chk("t4b_no_err", o_merr, 3'b000);
      end
      tick();
      host_ack   = 1'b1;
      host_rdata = 32'h0000_ACC0;
      expect_resp(3'b001, 3'b000, 32'h0000_ACC0);
      sample();
      tick();
      host_ack = 1'b0;
      drop_m(0);
      sample();
      chk("t4b_no_tmo", o_timeout, 1'b0);
      tick();
      sample();

      // ---- 5: device err, then ack+err together ----
      tick();
      drive_m(1, 1'b1, 1'b0, 32'h5000_0004, 32'h0, 4'h1);
      sample();
      tick();
      sample();
      chk("t5_grant", o_grant, 3'b010);
      tick();
      host_err   = 1'b1;
      host_rdata = 32'h1234_5678;
      expect_resp(3'b000, 3'b010, 32'h1234_5678);
      sample();
      chk("t5_mdata", o_mdata, 32'h1234_5678);
      tick();
      host_ack   = 1'b1;
      host_rdata = 32'h0000_00AE;
      expect_resp(3'b010, 3'b010, 32'h0000_00AE);
      sample();
      tick();
      host_ack = 1'b0;
      host_err = 1'b0;
      drop_m(1);
      sample();
      tick();
      sample();
      chk("t5_idle", o_grant, 3'b000);

      // ---- 6: async reset during BUSY, then 3-way tie goes to master 0 ----
      tick();
      for (int m = 0; m < NM; m++) begin
         drive_m(m, 1'b1, 1'b0, 32'h6000_0000 + 32'(m), 32'h0, 4'h2);
      end
      sample();
      tick();
      sample();
      chk("t6_grant_m2", o_grant,  3'b100);
      chk("t6_busy_cyc", host_cyc, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_rst_cyc",   host_cyc, 1'b0);
      chk("t6_rst_stb",   host_stb, 1'b0);
      chk("t6_rst_grant", o_grant,  3'b000);
      #1;
      rst = 1'b0;
      sample();
      chk("t6_after_rst_grant", o_grant, 3'b000);
      tick();
      sample();
      chk("t6_tie_m0",   o_grant,   3'b001);
      chk("t6_tie_addr", host_addr, 32'h6000_0000);
      tick();
      mcyc = '0;
      mstb = '0;
      sample();
      tick();
      sample();
      chk("t6_final_idle", o_grant, 3'b000);

      chk("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
